// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, arctangent table and state enum
package cordic_pkg;

    // Angles in Q3.13 radians
    localparam int PI_Q13      = 25736;
    localparam int HALF_PI_Q13 = 12868;

    // Inverse CORDIC gain 0.607253 in Q1.15
    localparam int K_Q15 = 19898;

    // atan(2^-i) in Q3.13, rounded
    localparam logic [15:0] ATAN_TAB [16] = '{
        16'd6434, 16'd3798, 16'd2007, 16'd1019,
        16'd511,  16'd256,  16'd128,  16'd64,
        16'd32,   16'd16,   16'd8,    16'd4,
        16'd2,    16'd1,    16'd0,    16'd0
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROT   = 2'd1,
        S_SCALE = 2'd2
    } cordic_state_e;

endpackage

// File: rtl/cordic_vectoring_if.sv
// rtl/cordic_vectoring_if.sv - request/result bundle of the vectoring CORDIC
interface cordic_vectoring_if #(
    parameter int WIDTH = 16
) ();
    logic                    start;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    busy;
    logic                    out_valid;
    logic [WIDTH+1:0]        mag_out;
    logic signed [WIDTH-1:0] phase_out;

    modport master (
        output start, x_in, y_in,
        input  busy, out_valid, mag_out, phase_out
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, out_valid, mag_out, phase_out
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - arctangent lookup, atan(2^-idx) in Q3.13
import cordic_pkg::*;

module cordic_atan_rom (
    input  logic [4:0]  idx,
    output logic [15:0] atan
);

    // Indices beyond the table return zero so the ROM is safe for any ITER
    always_comb begin
        atan = '0;
        if (idx < 5'd16) begin
            atan = ATAN_TAB[idx[3:0]];
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC (magnitude + atan2); CORDIC_VEC_GAIN_COMP_EN adds gain compensation
import cordic_pkg::*;

module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic              clk,
    input  logic              rst,
    cordic_vectoring_if.slave bus
);

    localparam int IW = $clog2(ITER + 1);
    localparam int XW = WIDTH + 3;

    cordic_state_e           state;
    logic [IW-1:0]           i;
    logic signed [XW-1:0]    x;
    logic signed [XW-1:0]    y;
    logic signed [WIDTH-1:0] z;
    logic                    zero_f;

    logic                    busy_r;
    logic                    valid_r;
    logic [WIDTH+1:0]        mag_r;
    logic signed [WIDTH-1:0] phase_r;

    logic [15:0]             atan_val;
    logic signed [WIDTH-1:0] atan_w;
    logic signed [XW-1:0]    x_sh;
    logic signed [XW-1:0]    y_sh;
    logic signed [XW-1:0]    xs;
    logic signed [XW-1:0]    ys;
    logic signed [XW-1:0]    x_cap;
    logic signed [XW-1:0]    y_cap;
    logic signed [WIDTH-1:0] z_cap;
    logic                    zero_cap;

    cordic_atan_rom u_atan_rom (
        .idx  (5'(i)),
        .atan (atan_val)
    );

    assign atan_w = WIDTH'(atan_val);
    assign x_sh   = x >>> i;
    assign y_sh   = y >>> i;

    assign bus.busy      = busy_r;
    assign bus.out_valid = valid_r;
    assign bus.mag_out   = mag_r;
    assign bus.phase_out = phase_r;

    // Quadrant pre-rotation folds the left half-plane into |angle| <= pi/2
    always_comb begin
        xs       = {{3{bus.x_in[WIDTH-1]}}, bus.x_in};
        ys       = {{3{bus.y_in[WIDTH-1]}}, bus.y_in};
        x_cap    = xs;
        y_cap    = ys;
        z_cap    = '0;
        zero_cap = (bus.x_in == '0) && (bus.y_in == '0);
        if (bus.x_in[WIDTH-1] && !bus.y_in[WIDTH-1]) begin
            x_cap = ys;
            y_cap = -xs;
            z_cap = WIDTH'(HALF_PI_Q13);
        end else if (bus.x_in[WIDTH-1]) begin
            x_cap = -ys;
            y_cap = xs;
            z_cap = WIDTH'(-HALF_PI_Q13);
        end
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [XW+16:0] prod;

    // Gain compensation multiply; x is non-negative so zero-extending K is exact
    always_comb begin
        prod = {{17{x[XW-1]}}, x} * {{XW{1'b0}}, 17'(K_Q15)};
    end
`endif

    // Control FSM and datapath: capture, micro-rotations, optional scale, result write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            i       <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            zero_f  <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            mag_r   <= '0;
            phase_r <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x      <= x_cap;
                        y      <= y_cap;
                        z      <= z_cap;
                        zero_f <= zero_cap;
                        i      <= '0;
                        busy_r <= 1'b1;
                        state  <= S_ROT;
                    end
                end
                S_ROT: begin
                    if (i == IW'(ITER)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        state   <= S_SCALE;
`else
                        mag_r   <= zero_f ? '0 : x[WIDTH+1:0];
                        phase_r <= zero_f ? '0 : z;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= S_IDLE;
`endif
                    end else begin
                        if (!y[XW-1]) begin
                            x <= x + y_sh;
                            y <= y - x_sh;
                            z <= z + atan_w;
                        end else begin
                            x <= x - y_sh;
                            y <= y + x_sh;
                            z <= z - atan_w;
                        end
                        i <= i + IW'(1);
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                S_SCALE: begin
                    mag_r   <= zero_f ? '0 : (WIDTH+2)'(prod >>> 15);
                    phase_r <= zero_f ? '0 : z;
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - scoreboard bench for cordic_vectoring
module tb_cordic_vectoring;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT      = ITER + 2;
    localparam int  MAG_TOL  = 4;
    localparam bit  COMP_ON  = 1'b1;
`else
    localparam int  LAT      = ITER + 1;
    localparam int  MAG_TOL  = 8;
    localparam bit  COMP_ON  = 1'b0;
`endif
    localparam int  PH_TOL   = 2;

    typedef struct {
        int    mag;
        int    phase;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    int   cap_q[$];

    cordic_vectoring_if #(.WIDTH(WIDTH)) bus ();

    cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic check_tol(input string nm, input int act, input int req, input int tol);
        checks++;
        if (absdiff(act, req) > tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d", nm, act, req, tol);
        end
    endtask

    // Monitor: pops one expectation per result pulse
    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cycle);
            end else begin
                e = exp_q.pop_front();
                check_tol({e.name, "_mag"}, int'(bus.mag_out), e.mag, MAG_TOL);
                check_tol({e.name, "_phase"}, int'(bus.phase_out), e.phase, PH_TOL);
                if (cap_q.size() > 0) begin
                    c = cap_q.pop_front();
                    check_tol({e.name, "_latency"}, cycle - c, LAT, 0);
                end
            end
        end
    end

    // Issue one request once the unit is free; expected result goes to the scoreboard
    task automatic issue(input int xv, input int yv, input int mag_true, input int mag_raw,
                         input int ph, input string nm);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL %s_busy_timeout actual=1 required=0", nm);
        end
        e.mag   = COMP_ON ? mag_true : mag_raw;
        e.phase = ph;
        e.name  = nm;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.x_in  = 16'(xv);
        bus.y_in  = 16'(yv);
        @(posedge clk);
        #1;
        cap_q.push_back(cycle);
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        cycle     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;

        repeat (3) @(negedge clk);
        check_tol("reset_busy", int'(bus.busy), 0, 0);
        check_tol("reset_valid", int'(bus.out_valid), 0, 0);
        check_tol("reset_mag", int'(bus.mag_out), 0, 0);
        check_tol("reset_phase", int'(bus.phase_out), 0, 0);
        rst = 1'b0;

        // Directed vectors; consecutive calls run back-to-back
        issue( 16384,      0, 16384, 26981,      0, "pos_x");
        issue(     0,  16384, 16384, 26981,  12868, "pos_y");
        issue(-16384,  16384, 23170, 38156,  19302, "q2_diag");
        issue(-32768,      0, 32768, 53961,  25736, "neg_full");
        issue(-16384, -16384, 23170, 38156, -19302, "q3_diag");
        issue(     0,      0,     0,     0,      0, "zero");
        issue(     0, -16384, 16384, 26981, -12868, "neg_y");

        // start pulsed while rotating must be ignored
        issue( 16384,  16384, 23170, 38156,   6434, "q1_diag");
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 16'sd0;
        bus.y_in  = 16'sd16384;
        @(negedge clk);
        bus.start = 1'b0;

        issue(-16384,      0, 16384, 26981,  25736, "neg_half");

        // Abort at iteration 5 with an asynchronous reset
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.x_in  = -16'sd16384;
        bus.y_in  = 16'sd16384;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_tol("abort_busy", int'(bus.busy), 0, 0);
        check_tol("abort_valid", int'(bus.out_valid), 0, 0);
        check_tol("abort_mag", int'(bus.mag_out), 0, 0);
        check_tol("abort_phase", int'(bus.phase_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (ITER + 6) @(negedge clk);

        issue( 16384,      0, 16384, 26981,      0, "after_abort");

        n = 0;
        while (exp_q.size() != 0 && n < 4 * ITER) begin
            @(negedge clk);
            n++;
        end
        repeat (ITER + 4) @(negedge clk);
        check_tol("scoreboard_drained", exp_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
